// File: rtl/alu_if.sv
// Operand/result bundle between an ALU client and the alu block.
// The master drives the operation; the slave returns the registered result.
interface alu_if #(
   parameter int unsigned WIDTH = 32
);
   logic [3:0]       control;
   logic [WIDTH-1:0] operand1;
   logic [WIDTH-1:0] operand2;
   logic [WIDTH-1:0] result;
   logic             zero;

   modport master (
      output control, operand1, operand2,
      input  result, zero
   );

   modport slave (
      input  control, operand1, operand2,
      output result, zero
   );
endinterface

// File: rtl/alu.sv
// Single-cycle registered ALU: logic, add/sub, shifts and compares.
// Result and its zero flag are captured together on every rising clock edge.
module alu #(
   parameter int unsigned WIDTH = 32
) (
   input logic  clk,
   input logic  rst,
   alu_if.slave bus
);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_SLL  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SRA  = 4'b1000;
   localparam logic [3:0] OP_SLTU = 4'b1001;
   localparam logic [3:0] OP_NOR  = 4'b1100;

   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [4:0]       shamt;
   logic [WIDTH-1:0] nxt;
   logic [WIDTH-1:0] result_q;
   logic             zero_q;

   assign a     = bus.operand1;
   assign b     = bus.operand2;
   assign shamt = b[4:0];

   always_comb begin
      nxt = '0;
      unique case (bus.control)
         OP_AND:  nxt = a & b;
         OP_OR:   nxt = a | b;
         OP_ADD:  nxt = a + b;
         OP_XOR:  nxt = a ^ b;
         OP_SLL:  nxt = a << shamt;
         OP_SRL:  nxt = a >> shamt;
         OP_SUB:  nxt = a - b;
         OP_SLT:  nxt[0] = ($signed(a) < $signed(b));
         OP_SRA:  nxt = $unsigned($signed(a) >>> shamt);
         OP_SLTU: nxt[0] = (a < b);
         OP_NOR:  nxt = ~(a | b);
         default: nxt = '0;
      endcase
   end

   // zero is derived from the same next value so the pair never disagrees
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_q <= '0;
         zero_q   <= 1'b1;
      end else begin
         result_q <= nxt;
         zero_q   <= (nxt == '0);
      end
   end

   assign bus.result = result_q;
   assign bus.zero   = zero_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: the driver queues expected outputs from a
// reference model, and a monitor compares them after every rising edge.
module tb_alu;

   typedef struct {
      logic [31:0] r;
      logic        z;
      string       name;
   } exp_t;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;
   exp_t q[$];

   alu_if #(.WIDTH(32)) bus ();

   alu #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t model(input logic [3:0] c, input logic [31:0] a,
                                  input logic [31:0] b, input string name);
      exp_t        e;
      logic [63:0] p;
      int unsigned n;
      logic [31:0] r;
      n = int'(b[4:0]);
      case (c)
         4'd0:  r = a & b;
         4'd1:  r = a | b;
         4'd2:  r = a + b;
         4'd3:  r = a ^ b;
         4'd4:  begin p = {32'd0, a} * (64'd1 << n); r = p[31:0]; end
         4'd5:  r = a >> n;
         4'd6:  r = a + ~b + 32'd1;
         4'd7:  r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
         4'd8:  r = (a >> n) | (a[31] ? ~(32'hFFFF_FFFF >> n) : 32'd0);
         4'd9:  r = (a < b) ? 32'd1 : 32'd0;
         4'd12: r = ~(a | b);
         default: r = 32'd0;
      endcase
      e.r = r;
      e.z = (r == 32'd0);
      e.name = name;
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] r, input logic z,
                        input logic [31:0] er, input logic ez);
      n_cmp++;
      if (r !== er || z !== ez) begin
         n_bad++;
         $display("FAIL %s: got result=%h zero=%b, expected result=%h zero=%b",
                  name, r, z, er, ez);
      end
   endtask

   task automatic drive(input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input string name);
      bus.control  = c;
      bus.operand1 = a;
      bus.operand2 = b;
      q.push_back(model(c, a, b, name));
   endtask

   task automatic issue(input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input string name);
      @(negedge clk);
      drive(c, a, b, name);
   endtask

   // monitor: one output per rising edge while anything is pending
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check(e.name, bus.result, bus.zero, e.r, e.z);
         end
      end
   end

   initial begin
      exp_t rz;
      logic [3:0]  c;
      logic [31:0] a, b;
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b1;
      bus.control  = 4'd2;
      bus.operand1 = 32'd5;
      bus.operand2 = 32'd7;
      #3;
      check("reset_async_initial", bus.result, bus.zero, 32'd0, 1'b1);
      @(negedge clk);
      check("reset_held_over_edge", bus.result, bus.zero, 32'd0, 1'b1);

      // first edge after deassert captures normally
      @(negedge clk);
      rst = 1'b0;
      drive(4'b0000, 32'hFFFF_0FF0, 32'h0FF0_FFFF, "and_directed");
      issue(4'b0001, 32'hFFFF_0000, 32'h0000_FFFF, "or_directed");
      issue(4'b1100, 32'hFFFF_0000, 32'h0000_FFFF, "nor_directed");
      issue(4'b0110, 32'hF0F0_F0F0, 32'hF0F0_F0F0, "sub_equal");
      issue(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, "add_wrap");
      issue(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, "slt_neg");
      issue(4'b1001, 32'hFFFF_FFFF, 32'h0000_0001, "sltu_big");
      issue(4'b0100, 32'h8000_0000, 32'h0000_0104, "sll_masked");
      issue(4'b0101, 32'h8000_0000, 32'h0000_0104, "srl_masked");
      issue(4'b1000, 32'h8000_0000, 32'h0000_0104, "sra_masked");
      issue(4'b1000, 32'h8765_4321, 32'hFFFF_FFE0, "sra_shift0");
      issue(4'b0100, 32'h0000_0001, 32'h0000_001F, "sll_31");
      issue(4'b1010, 32'h1234_5678, 32'h9ABC_DEF0, "undef_1010");
      issue(4'b0010, 32'h0000_0001, 32'h0000_0003, "add_directed");

      // mid-cycle reset while result holds 4, overriding the pending capture
      @(negedge clk);
      bus.control  = 4'b0001;
      bus.operand1 = 32'hFFFF_0000;
      bus.operand2 = 32'h0000_FFFF;
      #2 rst = 1'b1;
      #1;
      check("reset_async_midop", bus.result, bus.zero, 32'd0, 1'b1);
      rz.r = 32'd0;
      rz.z = 1'b1;
      rz.name = "reset_overrides_capture";
      q.push_back(rz);
      @(negedge clk);
      rst = 1'b0;
      drive(4'b1111, 32'hFFFF_FFFF, 32'h0000_0001, "undef_1111");

      // input changes between edges must not leak through before the edge
      issue(4'b0011, 32'hDEAD_BEEF, 32'h1234_5678, "xor_directed");
      #2;
      bus.operand1 = 32'h0;
      bus.operand2 = 32'h0;
      bus.control  = 4'b0011;
      void'(q.pop_back());
      q.push_back(model(4'b0011, 32'h0, 32'h0, "xor_last_value_wins"));

      for (int i = 0; i < 400; i++) begin
         c = 4'($urandom_range(0, 15));
         a = $urandom();
         b = $urandom();
         case ($urandom_range(0, 7))
            0: b = a;
            1: a = 32'hFFFF_FFFF;
            2: a = 32'h8000_0000;
            3: b = 32'h0000_0001;
            default: ;
         endcase
         issue(c, a, b, "random");
      end

      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending, expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width in bits (only 32 verified).
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Control  input  4  operation select, decoded per REQ-008.
REQ-005 Operand1  input  WIDTH  first operand (A).
REQ-006 Operand2  input  WIDTH  second operand (B); B[4:0] is the shift amount for shifts.
REQ-007 Zero  output  1  high when registered Result equals 0; Result  output  WIDTH  registered operation result.

Function
REQ-008 The block SHALL decode Control as follows:
- 0000 AND: A & B
- 0001 OR: A | B
- 0010 ADD: A + B, modulo 2^WIDTH
- 0011 XOR: A ^ B
- 0100 SLL: A << B[4:0]
- 0101 SRL: A >> B[4:0], logical, zero fill
- 0110 SUB: A - B, modulo 2^WIDTH
- 0111 SLT: 1 if A < B as signed two's complement, else 0
- 1000 SRA: A >>> B[4:0], arithmetic, sign fill
- 1001 SLTU: 1 if A < B as unsigned, else 0
- 1100 NOR: ~(A | B)
REQ-009 All other Control codes (1010, 1011, 1101, 1110, 1111) SHALL produce Result = 0.
REQ-010 The operation SHALL be computed combinationally from the current Control, Operand1 and Operand2, and captured into Result on every rising Clk edge; latency is exactly 1 cycle and there is no enable or handshake.
REQ-011 Zero SHALL be registered on the same edge as Result and equal (next Result == 0), so Zero and Result are always mutually consistent.
REQ-012 ADD and SUB SHALL wrap silently with no carry or overflow output (e.g. 0xFFFFFFFF + 1 gives 0 and sets Zero).
REQ-013 SLT and SLTU results SHALL be zero-extended to WIDTH, with bit 0 carrying the comparison.
REQ-014 Shift amounts SHALL use only B[4:0] (0..31); upper bits of B SHALL be ignored, and a shift of 0 SHALL pass A unchanged.
REQ-015 Input changes between clock edges SHALL NOT affect the outputs until the next rising edge.

Reset
REQ-016 While Reset is high, Result SHALL be 0 and Zero SHALL be 1, immediately and without waiting for a clock edge.
REQ-017 Reset asserted mid-operation SHALL override any pending capture.
REQ-018 On the first rising edge after Reset deasserts, the block SHALL capture the current inputs normally.

Verification
REQ-019 AND: Control=0000, A=0xFFFF0FF0, B=0x0FF0FFFF -> one edge later Result=0x0FF00FF0, Zero=0.
REQ-020 OR: Control=0001, A=0xFFFF0000, B=0x0000FFFF -> Result=0xFFFFFFFF, Zero=0; then NOR with the same operands -> Result=0, Zero=1.
REQ-021 ADD/SUB: 0010 with A=1, B=3 -> Result=4; 0110 with A=B=0xF0F0F0F0 -> Result=0, Zero=1; 0010 with A=0xFFFFFFFF, B=1 -> Result=0, Zero=1.
REQ-022 Compare: A=0xFFFFFFFF, B=1 -> SLT (0111) gives 1, SLTU (1001) gives 0.
REQ-023 Shifts: A=0x80000000, B=0x00000104 -> SLL gives 0, SRL gives 0x08000000, SRA gives 0xF8000000.
REQ-024 Reset: assert Reset between edges while Result=4 -> Result=0 and Zero=1 immediately; an undefined Control code (1111) gives Result=0.
